cell_writer: RTL and testbench
==============================

// Module: cell_writer
// PURPOSE
//  Ingress segmenter for the shared cell buffer.
//  - Accepts one frame as a byte stream, allocates cells from the free list and writes payload bytes into the buffer.
//  - Writes each cell's footer_t (next_idx, eop) in its last FOOTER_BYTES.
//  - Emits a descriptor (head, tail, length) per frame to the queue manager.
// PARAMETERS
//  BLOCK_BYTES    mem_pkg::BLOCK_BYTES    cell size in bytes (power of 2)
//  ADDR_W         mem_pkg::ADDR_W         cell index width
//  FOOTER_BYTES   mem_pkg::FOOTER_BYTES   footer bytes per cell (2)
//  LEN_W          16                      frame length counter width
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous reset, active-high
//  in_data        in   8                    frame byte
//  in_valid       in   1                    in_data valid
//  in_last        in   1                    final byte of frame
//  in_ready       out  1                    byte accepted when in_valid&in_ready
//  alloc_req      out  1                    request a free cell
//  alloc_gnt      in   1                    grant; alloc_idx valid this cycle
//  alloc_idx      in   ADDR_W               granted cell index
//  mem_we         out  1                    buffer byte write strobe
//  mem_addr       out  ADDR_W+log2(BLOCK_BYTES)   {cell_idx, byte_off}
//  mem_wdata      out  8                    write byte
//  pkt_valid      out  1                    descriptor valid
//  pkt_ready      in   1                    descriptor consumed when valid&ready
//  pkt_head_idx   out  ADDR_W               first cell of frame
//  pkt_tail_idx   out  ADDR_W               last cell of frame
//  pkt_len        out  LEN_W                frame length in bytes
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM returns to IDLE.
//  - Reset mid-frame abandons the frame: allocated cells are not returned; the free list is reset with this block.
//  FSM states: IDLE, ALLOC, PAYLOAD, FOOT_HI, FOOT_LO, DESC.
//  IDLE
//  - in_ready=0.
//  - in_valid=1 -> ALLOC (head=1).
//  ALLOC
//  - alloc_req=1; held until alloc_gnt (an empty free list simply stalls).
//  - On gnt with head=1: cur_idx=alloc_idx, head_idx=alloc_idx, off=0 -> PAYLOAD.
//  - On gnt with head=0: nxt_idx=alloc_idx -> FOOT_HI.
//  PAYLOAD
//  - in_ready=1. Each accepted byte writes {cur_idx,off} and increments off and len.
//  - len saturates at 2^LEN_W-1.
//  - Accepted byte with in_last=1: eop=1, nxt_idx=0 -> FOOT_HI.
//  - Accepted byte without last that fills off=PAYLOAD_BYTES-1: in_ready drops next cycle; -> ALLOC (head=0).
//  - in_valid=0: hold, no write.
//  FOOT_HI
//  - Write offset BLOCK_BYTES-2 with footer[15:8].
//  - footer = {nxt_idx, eop, 3'b0}.
//  FOOT_LO
//  - Write offset BLOCK_BYTES-1 with footer[7:0].
//  - eop=0: cur_idx=nxt_idx, off=0 -> PAYLOAD.
//  - eop=1: tail=cur_idx -> DESC.
//  DESC
//  - pkt_valid=1; fields stable until pkt_ready.
//  - On handshake: clear len/eop -> IDLE.
//  - in_ready=0 throughout; back-pressure holds the next frame.
//  Timing
//  - mem_we/addr/wdata are registered: the write appears the cycle after the accepting edge.
//  - Exactly one write per byte and two per cell footer.
//  - Unused payload bytes of the tail cell are not written.
//  - Throughput: 1 byte/cycle within a cell; ≥3 cycles overhead per cell boundary, plus grant wait.
// TESTING
//  T1: 1-byte frame 0xAB, gnt idx 5
//      -> writes (5,0)=AB, (5,62)=0x00, (5,63)=0x08
//      -> pkt head=5 tail=5 len=1
//  T2: 62-byte frame, gnt 3
//      -> one cell; footer eop=1, next=0
//      -> no second alloc_req; len=62
//  T3: 63-byte frame, gnts 3 then 9
//      -> cell 3 footer bytes 0x00,0x90 (next=9, eop=0)
//      -> byte 63 at (9,0); cell 9 footer eop=1; head=3 tail=9
//  T4: alloc_gnt withheld 20 cycles at the boundary of a 100-byte frame
//      -> in_ready=0 throughout; no writes; resumes intact
//  T5: pkt_ready low 10 cycles, next frame pending
//      -> descriptor stable; in_ready=0; second frame processed after handshake
//  T6: rst asserted mid-PAYLOAD
//      -> next cycle all outputs 0, FSM IDLE; fresh frame completes normally

Source files
------------

// File: rtl/cell_writer.sv
// Ingress segmenter: splits one byte-stream frame across free-list cells, writes each
// cell's {next_idx, eop} footer and hands a (head, tail, length) descriptor downstream.
module cell_writer #(
  parameter int BLOCK_BYTES  = 64,
  parameter int ADDR_W       = 12,
  parameter int FOOTER_BYTES = 2,
  parameter int LEN_W        = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [7:0]                            i_in_data,
  input  logic                                  i_in_valid,
  input  logic                                  i_in_last,
  output logic                                  o_in_ready,
  output logic                                  o_alloc_req,
  input  logic                                  i_alloc_gnt,
  input  logic [ADDR_W-1:0]                     i_alloc_idx,
  output logic                                  o_mem_we,
  output logic [ADDR_W+$clog2(BLOCK_BYTES)-1:0] o_mem_addr,
  output logic [7:0]                            o_mem_wdata,
  output logic                                  o_pkt_valid,
  input  logic                                  i_pkt_ready,
  output logic [ADDR_W-1:0]                     o_pkt_head_idx,
  output logic [ADDR_W-1:0]                     o_pkt_tail_idx,
  output logic [LEN_W-1:0]                      o_pkt_len
);

  localparam int OFF_W         = $clog2(BLOCK_BYTES);
  localparam int PAYLOAD_BYTES = BLOCK_BYTES - FOOTER_BYTES;
  localparam int PAD_W         = 16 - ADDR_W - 1;

  localparam logic [OFF_W-1:0] OFF_LAST_PAY = OFF_W'(PAYLOAD_BYTES - 1);
  localparam logic [OFF_W-1:0] OFF_FOOT_HI  = OFF_W'(BLOCK_BYTES - 2);
  localparam logic [OFF_W-1:0] OFF_FOOT_LO  = OFF_W'(BLOCK_BYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ALLOC   = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_FOOT_HI = 3'd3;
  localparam logic [2:0] S_FOOT_LO = 3'd4;
  localparam logic [2:0] S_DESC    = 3'd5;

  logic [2:0]                r_state;
  logic                      r_head;
  logic                      r_eop;
  logic [OFF_W-1:0]          r_off;
  logic [LEN_W-1:0]          r_len;
  logic [ADDR_W-1:0]         r_cur_idx;
  logic [ADDR_W-1:0]         r_nxt_idx;
  logic [ADDR_W-1:0]         r_head_idx;
  logic [ADDR_W-1:0]         r_tail_idx;
  logic                      r_we;
  logic [ADDR_W+OFF_W-1:0]   r_addr;
  logic [7:0]                r_wdata;

  logic                      w_acc;
  logic                      w_gnt;
  logic [15:0]               w_footer;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign w_acc    = (r_state == S_PAYLOAD) && i_in_valid;
  assign w_gnt    = (r_state == S_ALLOC) && i_alloc_gnt;
  assign w_footer = {r_nxt_idx, r_eop, {PAD_W{1'b0}}};

  // Cell indices are pure data: every use is preceded by a grant that loads them.
  always_ff @(posedge i_clk) begin
    if (w_gnt && r_head) begin
      r_cur_idx <= i_alloc_idx;
    end else if ((r_state == S_FOOT_LO) && !r_eop) begin
      r_cur_idx <= r_nxt_idx;
    end
    if (w_acc && i_in_last) begin
      r_nxt_idx <= '0;
    end else if (w_gnt && !r_head) begin
      r_nxt_idx <= i_alloc_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_head     <= 1'b0;
      r_eop      <= 1'b0;
      r_off      <= '0;
      r_len      <= '0;
      r_head_idx <= '0;
      r_tail_idx <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_head  <= 1'b1;
            r_state <= S_ALLOC;
          end
        end
        S_ALLOC: begin
          if (i_alloc_gnt) begin
            if (r_head) begin
              r_head_idx <= i_alloc_idx;
              r_off      <= '0;
              r_head     <= 1'b0;
              r_state    <= S_PAYLOAD;
            end else begin
              r_state <= S_FOOT_HI;
            end
          end
        end
        S_PAYLOAD: begin
          if (i_in_valid) begin
            r_we    <= 1'b1;
            r_addr  <= {r_cur_idx, r_off};
            r_wdata <= i_in_data;
            r_off   <= r_off + OFF_W'(1);
            r_len   <= sat_inc(r_len);
            if (i_in_last) begin
              r_eop   <= 1'b1;
              r_state <= S_FOOT_HI;
            end else if (r_off == OFF_LAST_PAY) begin
              r_state <= S_ALLOC;
            end
          end
        end
        S_FOOT_HI: begin
          r_we    <= 1'b1;
          r_addr  <= {r_cur_idx, OFF_FOOT_HI};
          r_wdata <= w_footer[15:8];
          r_state <= S_FOOT_LO;
        end
        S_FOOT_LO: begin
          r_we    <= 1'b1;
          r_addr  <= {r_cur_idx, OFF_FOOT_LO};
          r_wdata <= w_footer[7:0];
          if (r_eop) begin
            r_tail_idx <= r_cur_idx;
            r_state    <= S_DESC;
          end else begin
            r_off   <= '0;
            r_state <= S_PAYLOAD;
          end
        end
        S_DESC: begin
          if (i_pkt_ready) begin
            r_len   <= '0;
            r_eop   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready     = (r_state == S_PAYLOAD);
  assign o_alloc_req    = (r_state == S_ALLOC);
  assign o_pkt_valid    = (r_state == S_DESC);
  assign o_mem_we       = r_we;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;
  assign o_pkt_head_idx = r_head_idx;
  assign o_pkt_tail_idx = r_tail_idx;
  assign o_pkt_len      = r_len;

endmodule

// File: tb/tb_cell_writer.sv
// Bench for cell_writer: directed frames against a frame-level write/descriptor model.
module tb_cell_writer;
  localparam int BB = 64;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int OW = 6;
  localparam int PB = 62;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [7:0]    i_in_data;
  logic          i_in_valid;
  logic          i_in_last;
  logic          o_in_ready;
  logic          o_alloc_req;
  logic          i_alloc_gnt;
  logic [AW-1:0] i_alloc_idx;
  logic          o_mem_we;
  logic [AW+OW-1:0] o_mem_addr;
  logic [7:0]    o_mem_wdata;
  logic          o_pkt_valid;
  logic          i_pkt_ready;
  logic [AW-1:0] o_pkt_head_idx;
  logic [AW-1:0] o_pkt_tail_idx;
  logic [LW-1:0] o_pkt_len;

  always #5 clk = ~clk;

  cell_writer #(.BLOCK_BYTES(BB), .ADDR_W(AW), .FOOTER_BYTES(2), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .i_in_last(i_in_last), .o_in_ready(o_in_ready),
    .o_alloc_req(o_alloc_req), .i_alloc_gnt(i_alloc_gnt), .i_alloc_idx(i_alloc_idx),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready),
    .o_pkt_head_idx(o_pkt_head_idx), .o_pkt_tail_idx(o_pkt_tail_idx), .o_pkt_len(o_pkt_len)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Model state: pending source bytes, pending grants, expected writes and descriptors
  logic [8:0]       src_q[$];
  logic [AW-1:0]    gnt_q[$];
  logic [AW+OW-1:0] exp_wa[$];
  logic [7:0]       exp_wd[$];
  logic [AW-1:0]    exp_dh[$];
  logic [AW-1:0]    exp_dt[$];
  logic [LW-1:0]    exp_dl[$];
  logic [AW+OW-1:0] log_a[$];
  logic [7:0]       log_d[$];

  logic [AW-1:0] ld_h, ld_t, cur_h, cur_t;
  logic [LW-1:0] ld_l, cur_l;
  int  desc_done = 0;
  bit  d_active = 0;
  bit  mon_en = 0;
  bit  p_acc = 0, p_gnt = 0;
  bit  sink_en = 1, gap_mode = 0;
  int  gnt_delay = 0, gnt_wait = 0, cyc = 0, areq_cnt = 0;

  task automatic send_frame(input int len, input logic [7:0] seed,
                            input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] idx[2];
    int ncell, hi, ftr;
    logic [7:0] bv;
    idx[0] = a;
    idx[1] = b;
    ncell = (len + PB - 1) / PB;
    for (int i = 0; i < len; i++) begin
      bv = seed + 8'(i);
      src_q.push_back({(i == len - 1), bv});
    end
    for (int c = 0; c < ncell; c++) begin
      gnt_q.push_back(idx[c]);
      hi = ((c + 1) * PB < len) ? (c + 1) * PB : len;
      for (int j = c * PB; j < hi; j++) begin
        bv = seed + 8'(j);
        exp_wa.push_back((AW+OW)'(idx[c] * BB + (j - c * PB)));
        exp_wd.push_back(bv);
      end
      ftr = ((c < ncell - 1) ? idx[c + 1] * 16 : 0) + ((c == ncell - 1) ? 8 : 0);
      exp_wa.push_back((AW+OW)'(idx[c] * BB + BB - 2));
      exp_wd.push_back(8'(ftr >> 8));
      exp_wa.push_back((AW+OW)'(idx[c] * BB + BB - 1));
      exp_wd.push_back(8'(ftr & 255));
    end
    exp_dh.push_back(a);
    exp_dt.push_back(idx[ncell - 1]);
    exp_dl.push_back(LW'((len > 65535) ? 65535 : len));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (p_acc) void'(src_q.pop_front());
    if (p_gnt) void'(gnt_q.pop_front());
    if (o_alloc_req) areq_cnt++;
    i_alloc_gnt = 1'b0;
    i_alloc_idx = '0;
    if (o_alloc_req && gnt_q.size() > 0) begin
      if (gnt_wait < gnt_delay) gnt_wait++;
      else begin
        i_alloc_gnt = 1'b1;
        i_alloc_idx = gnt_q[0];
        gnt_wait = 0;
      end
    end
    i_in_valid = (src_q.size() > 0) && !(gap_mode && (cyc % 3 == 0));
    {i_in_last, i_in_data} = (src_q.size() > 0) ? src_q[0] : 9'h0;
    i_pkt_ready = sink_en;
    p_acc = i_in_valid && o_in_ready && !i_rst;
    p_gnt = i_alloc_gnt && !i_rst;
  endtask

  task automatic flush_model();
    src_q.delete(); gnt_q.delete();
    exp_wa.delete(); exp_wd.delete();
    exp_dh.delete(); exp_dt.delete(); exp_dl.delete();
    d_active = 0;
    p_acc = 0; p_gnt = 0; gnt_wait = 0;
    i_in_valid = 1'b0; i_in_last = 1'b0; i_in_data = '0;
    i_alloc_gnt = 1'b0; i_alloc_idx = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(o_in_ready), 0);
    check({tag, "_alloc_req"}, 32'(o_alloc_req), 0);
    check({tag, "_mem_we"}, 32'(o_mem_we), 0);
    check({tag, "_mem_addr"}, 32'(o_mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(o_mem_wdata), 0);
    check({tag, "_pkt_valid"}, 32'(o_pkt_valid), 0);
    check({tag, "_head"}, 32'(o_pkt_head_idx), 0);
    check({tag, "_tail"}, 32'(o_pkt_tail_idx), 0);
    check({tag, "_len"}, 32'(o_pkt_len), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (src_q.size() == 0) && (exp_wa.size() == 0) && (exp_dh.size() == 0) && !d_active
             && !o_pkt_valid;
    end
    check({tag, "_completed"}, 32'(done), 1);
    if (!done) begin
      i_rst = 1'b1;
      tick();
      flush_model();
      i_rst = 1'b0;
    end
  endtask

  // Every cycle: writes against the model, descriptor content/stability, in_ready interlock
  initial begin
    logic [AW+OW-1:0] ea;
    logic [7:0] ed;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_mem_we) begin
          log_a.push_back(o_mem_addr);
          log_d.push_back(o_mem_wdata);
          if (exp_wa.size() == 0) begin
            check("write_expected", 0, 1);
          end else begin
            ea = exp_wa.pop_front();
            ed = exp_wd.pop_front();
            check("wr_addr", 32'(o_mem_addr), 32'(ea));
            check("wr_data", 32'(o_mem_wdata), 32'(ed));
          end
        end
        if (o_pkt_valid) begin
          check("in_ready_during_desc", 32'(o_in_ready), 0);
          if (!d_active) begin
            if (exp_dh.size() == 0) check("desc_expected", 0, 1);
            else begin
              cur_h = exp_dh.pop_front();
              cur_t = exp_dt.pop_front();
              cur_l = exp_dl.pop_front();
            end
            d_active = 1;
          end
          check("desc_head", 32'(o_pkt_head_idx), 32'(cur_h));
          check("desc_tail", 32'(o_pkt_tail_idx), 32'(cur_t));
          check("desc_len", 32'(o_pkt_len), 32'(cur_l));
          if (i_pkt_ready) begin
            d_active = 0;
            ld_h = o_pkt_head_idx;
            ld_t = o_pkt_tail_idx;
            ld_l = o_pkt_len;
            desc_done++;
          end
        end
        if (o_alloc_req) check("in_ready_during_alloc", 32'(o_in_ready), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, d0;
    i_rst = 1'b1;
    i_in_valid = 1'b0; i_in_last = 1'b0; i_in_data = '0;
    i_alloc_gnt = 1'b0; i_alloc_idx = '0; i_pkt_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    i_rst = 1'b0;
    mon_en = 1;

    // T1: single byte frame
    log_a.delete(); log_d.delete();
    send_frame(1, 8'hAB, 12'd5, 12'd0);
    wait_done("t1", 100);
    check("t1_nwrites", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("t1_w0_addr", 32'(log_a[0]), 32'h140);
      check("t1_w0_data", 32'(log_d[0]), 32'hAB);
      check("t1_w1_addr", 32'(log_a[1]), 32'h17E);
      check("t1_w1_data", 32'(log_d[1]), 32'h00);
      check("t1_w2_addr", 32'(log_a[2]), 32'h17F);
      check("t1_w2_data", 32'(log_d[2]), 32'h08);
    end
    check("t1_head", 32'(ld_h), 5);
    check("t1_tail", 32'(ld_t), 5);
    check("t1_len", 32'(ld_l), 1);

    // T2: exactly one full cell of payload
    log_a.delete(); log_d.delete();
    areq_cnt = 0;
    send_frame(62, 8'h10, 12'd3, 12'd0);
    wait_done("t2", 200);
    check("t2_alloc_cycles", areq_cnt, 1);
    check("t2_nwrites", log_a.size(), 64);
    if (log_a.size() == 64) check("t2_footer_lo", 32'(log_d[63]), 32'h08);
    check("t2_len", 32'(ld_l), 62);

    // T3: one byte spills into a second cell
    log_a.delete(); log_d.delete();
    send_frame(63, 8'h20, 12'd3, 12'd9);
    wait_done("t3", 200);
    check("t3_nwrites", log_a.size(), 67);
    if (log_a.size() == 67) begin
      check("t3_c3_fhi_addr", 32'(log_a[62]), 32'h0FE);
      check("t3_c3_fhi_data", 32'(log_d[62]), 32'h00);
      check("t3_c3_flo_addr", 32'(log_a[63]), 32'h0FF);
      check("t3_c3_flo_data", 32'(log_d[63]), 32'h90);
      check("t3_b63_addr", 32'(log_a[64]), 32'h240);
      check("t3_b63_data", 32'(log_d[64]), 32'h5E);
      check("t3_c9_flo_data", 32'(log_d[66]), 32'h08);
    end
    check("t3_head", 32'(ld_h), 3);
    check("t3_tail", 32'(ld_t), 9);
    check("t3_len", 32'(ld_l), 63);

    // T4: every grant held back 20 cycles, source with idle gaps
    gnt_delay = 20;
    gap_mode = 1;
    areq_cnt = 0;
    send_frame(100, 8'h40, 12'd11, 12'd12);
    wait_done("t4", 500);
    check("t4_alloc_cycles", areq_cnt, 42);
    check("t4_head", 32'(ld_h), 11);
    check("t4_tail", 32'(ld_t), 12);
    check("t4_len", 32'(ld_l), 100);
    gnt_delay = 0;
    gap_mode = 0;

    // T5: descriptor back-pressure with the next frame already waiting
    sink_en = 0;
    d0 = desc_done;
    send_frame(5, 8'h60, 12'd7, 12'd0);
    send_frame(3, 8'h70, 12'd8, 12'd0);
    n = 0;
    while (!o_pkt_valid && n < 50) begin
      tick();
      n++;
    end
    check("t5_desc_seen", 32'(o_pkt_valid), 1);
    repeat (10) begin
      tick();
      check("t5_hold_valid", 32'(o_pkt_valid), 1);
      check("t5_hold_in_ready", 32'(o_in_ready), 0);
      check("t5_hold_len", 32'(o_pkt_len), 5);
    end
    sink_en = 1;
    wait_done("t5", 100);
    check("t5_desc_count", desc_done - d0, 2);
    check("t5_second_head", 32'(ld_h), 8);
    check("t5_second_len", 32'(ld_l), 3);

    // T6: reset in the middle of the payload, then a clean frame
    log_a.delete(); log_d.delete();
    send_frame(30, 8'h80, 12'd4, 12'd0);
    n = 0;
    while (log_a.size() < 10 && n < 100) begin
      tick();
      n++;
    end
    check("t6_midframe_reached", 32'(log_a.size() >= 10), 1);
    i_rst = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    flush_model();
    i_rst = 1'b0;
    tick();
    check("t6_idle_no_req", 32'(o_alloc_req), 0);
    base = desc_done;
    send_frame(4, 8'h90, 12'd6, 12'd0);
    wait_done("t6", 100);
    check("t6_desc_count", desc_done - base, 1);
    check("t6_head", 32'(ld_h), 6);
    check("t6_len", 32'(ld_l), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
